// File: rtl/l0_skew_buffer_if.sv
// Write/read bus of the L0 skew buffer: write vector, read request, mode and registered lane outputs.
interface l0_skew_buffer_if #(
  parameter int unsigned ROW   = 8,
  parameter int unsigned BW    = 4,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ROW*BW-1:0] in;
  logic              wr;
  logic              rd;
  logic [1:0]        mode;
  logic [ROW*BW-1:0] out;
  logic [ROW-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_empty;
  logic [CW-1:0]     o_count;
  logic              o_ovf;
  logic              o_udf;

  modport master (
    output in, wr, rd, mode,
    input  out, o_valid, o_full, o_ready, o_empty, o_count, o_ovf, o_udf
  );

  modport slave (
    input  in, wr, rd, mode,
    output out, o_valid, o_full, o_ready, o_empty, o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/l0_skew_buffer.sv
// ROW parallel FIFO lanes feeding the MAC array west edge; broadcast, skewed-wavefront
// or round-robin read, with registered lane outputs and sticky overflow/underflow flags.
module l0_skew_buffer #(
  parameter int unsigned ROW   = 8,
  parameter int unsigned BW    = 4,
  parameter int unsigned DEPTH = 64
) (
  input logic              clk,
  input logic              reset,
  l0_skew_buffer_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] MODE_BCAST = 2'd0;
  localparam logic [1:0] MODE_SKEW  = 2'd1;
  localparam logic [1:0] MODE_RR    = 2'd2;

  logic [BW-1:0]     mem [ROW][DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr [ROW];
  logic [CW-1:0]     count [ROW];
  logic [1:0]        mode_q;
  logic [ROW-1:1]    skew_q;
  logic [ROW-1:0]    rr_q;
  logic [ROW*BW-1:0] out_q;
  logic [ROW-1:0]    valid_q;
  logic              full_q, ready_q, empty_q, ovf_q, udf_q;

  logic              mode_chg;
  logic [1:0]        eff_mode;
  logic [ROW-1:1]    skew_cur, skew_nxt;
  logic [ROW-1:0]    rr_cur, rr_nxt;
  logic [ROW-1:0]    en, pop;
  logic              push, ovf_hit, udf_hit, any_full, all_empty;
  logic [CW-1:0]     count_nxt [ROW];

  // Per-lane read enables; a mode change cancels delayed reads and rewinds the rr pointer
  always_comb begin
    mode_chg = (bus.mode != mode_q);
    eff_mode = (bus.mode == 2'd3) ? MODE_BCAST : bus.mode;
    skew_cur = mode_chg ? '0 : skew_q;
    rr_cur   = mode_chg ? ROW'(1) : rr_q;
    en       = '0;
    case (eff_mode)
      MODE_SKEW: en = {skew_cur, bus.rd};
      MODE_RR:   en = bus.rd ? rr_cur : '0;
      default:   en = {ROW{bus.rd}};
    endcase
    skew_nxt    = '0;
    skew_nxt[1] = bus.rd;
    for (int unsigned i = 2; i < ROW; i++) skew_nxt[i] = skew_cur[i-1];
    rr_nxt = (eff_mode == MODE_RR && bus.rd) ? {rr_cur[ROW-2:0], rr_cur[ROW-1]} : rr_cur;
  end

  // Push/pop decisions use the pre-pop full flag, so a full lane refuses writes even while draining
  always_comb begin
    push      = bus.wr & ~full_q;
    ovf_hit   = bus.wr & full_q;
    pop       = '0;
    udf_hit   = 1'b0;
    any_full  = 1'b0;
    all_empty = 1'b1;
    for (int unsigned i = 0; i < ROW; i++) begin
      pop[i]       = en[i] & (count[i] != '0);
      udf_hit      = udf_hit | (en[i] & (count[i] == '0));
      count_nxt[i] = count[i] + CW'(push) - CW'(pop[i]);
      any_full     = any_full | (count_nxt[i] == CW'(DEPTH));
      all_empty    = all_empty & (count_nxt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < ROW; i++) mem[i][wr_ptr] <= bus.in[i*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      mode_q  <= MODE_BCAST;
      skew_q  <= '0;
      rr_q    <= ROW'(1);
      out_q   <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int unsigned i = 0; i < ROW; i++) begin
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      mode_q  <= bus.mode;
      skew_q  <= skew_nxt;
      rr_q    <= rr_nxt;
      valid_q <= pop;
      full_q  <= any_full;
      ready_q <= ~any_full;
      empty_q <= all_empty;
      ovf_q   <= ovf_q | ovf_hit;
      udf_q   <= udf_q | udf_hit;
      for (int unsigned i = 0; i < ROW; i++) begin
        count[i] <= count_nxt[i];
        if (pop[i]) begin
          out_q[i*BW +: BW] <= mem[i][rd_ptr[i]];
          rd_ptr[i]         <= rd_ptr[i] + PW'(1);
        end
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = valid_q;
  assign bus.o_full  = full_q;
  assign bus.o_ready = ready_q;
  assign bus.o_empty = empty_q;
  assign bus.o_count = count[0];
  assign bus.o_ovf   = ovf_q;
  assign bus.o_udf   = udf_q;
endmodule

// File: tb/tb_l0_skew_buffer.sv
// Self-checking bench for l0_skew_buffer: directed vector table, corner sequences and
// randomized traffic against a queue-based lane model.
module tb_l0_skew_buffer;
  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam logic [31:0] V0 = 32'h7654_3210;
  localparam logic [31:0] V1 = 32'hFEDC_BA98;

  logic clk;
  logic reset;
  l0_skew_buffer_if #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) bus ();

  l0_skew_buffer #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per lane plus a history of past read requests
  logic [BW-1:0]     mq [ROW][$];
  bit                hist [$];
  logic [1:0]        m_mode;
  int                rr;
  logic [ROW*BW-1:0] m_out;
  logic [ROW-1:0]    m_valid;
  bit                m_ovf, m_udf;

  typedef struct {
    bit          rst, wr, rd;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] e_out;
    logic [7:0]  e_valid;
    int          e_count;
    bit          e_empty, e_udf;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < ROW; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, input bit w, input bit r, input logic [1:0] md,
                            input logic [ROW*BW-1:0] din);
    logic [ROW-1:0] en;
    bit full;
    int eff;
    if (rst) begin
      for (int i = 0; i < ROW; i++) mq[i].delete();
      hist.delete();
      m_mode = 2'd0; rr = 0; m_out = '0; m_valid = '0; m_ovf = 0; m_udf = 0;
      return;
    end
    full = m_full();
    eff  = (md == 2'd3) ? 0 : int'(md);
    if (md != m_mode) begin
      hist.delete();
      rr = 0;
    end
    en = '0;
    if (eff == 0) begin
      en = r ? '1 : '0;
    end else if (eff == 1) begin
      en[0] = r;
      for (int i = 1; i < ROW; i++) en[i] = (i - 1 < hist.size()) ? hist[i-1] : 1'b0;
    end else if (r) begin
      en[rr] = 1'b1;
      rr = (rr + 1) % ROW;
    end
    hist.push_front(r);
    if (hist.size() > ROW - 1) void'(hist.pop_back());
    m_valid = '0;
    for (int i = 0; i < ROW; i++) begin
      if (en[i]) begin
        if (mq[i].size() > 0) begin
          m_out[i*BW +: BW] = mq[i].pop_front();
          m_valid[i] = 1'b1;
        end else m_udf = 1'b1;
      end
    end
    if (w) begin
      if (full) m_ovf = 1'b1;
      else for (int i = 0; i < ROW; i++) mq[i].push_back(din[i*BW +: BW]);
    end
    m_mode = md;
  endtask

  task automatic compare_all();
    chk("out",     bus.out,     m_out);
    chk("o_valid", bus.o_valid, m_valid);
    chk("o_count", bus.o_count, mq[0].size());
    chk("o_full",  bus.o_full,  m_full());
    chk("o_ready", bus.o_ready, !m_full());
    chk("o_empty", bus.o_empty, m_empty());
    chk("o_ovf",   bus.o_ovf,   m_ovf);
    chk("o_udf",   bus.o_udf,   m_udf);
  endtask

  task automatic cycle(input bit rst, input bit w, input bit r, input logic [1:0] md,
                       input logic [ROW*BW-1:0] din);
    reset = rst; bus.wr = w; bus.rd = r; bus.mode = md; bus.in = din;
    model_step(rst, w, r, md, din);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic add(input bit rst, input bit w, input bit r, input logic [1:0] md,
                     input logic [31:0] din, input logic [31:0] eo, input logic [7:0] ev,
                     input int ec, input bit ee, input bit eu);
    vec_t v;
    v.rst = rst; v.wr = w; v.rd = r; v.mode = md; v.din = din;
    v.e_out = eo; v.e_valid = ev; v.e_count = ec; v.e_empty = ee; v.e_udf = eu;
    vt.push_back(v);
  endtask

  logic [31:0] sk_out [10] = '{32'h0000_0000, 32'h0000_0018, 32'h0000_0298, 32'h0000_3A98,
                               32'h0004_BA98, 32'h005C_BA98, 32'h06DC_BA98, 32'h7EDC_BA98,
                               32'hFEDC_BA98, 32'hFEDC_BA98};
  logic [7:0]  sk_val [10] = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0,
                               8'h80, 8'h00};

  initial begin
    logic [31:0] mask;
    reset = 1'b1; bus.wr = 0; bus.rd = 0; bus.mode = 2'd0; bus.in = '0;

    // Broadcast: two writes then two reads
    add(1, 0, 0, 0, 0,  0,  8'h00, 0, 1, 0);
    add(0, 1, 0, 0, V0, 0,  8'h00, 1, 0, 0);
    add(0, 1, 0, 0, V1, 0,  8'h00, 2, 0, 0);
    add(0, 0, 1, 0, 0,  V0, 8'hFF, 1, 0, 0);
    add(0, 0, 1, 0, 0,  V1, 8'hFF, 0, 1, 0);
    add(0, 0, 0, 0, 0,  V1, 8'h00, 0, 1, 0);
    // Round-robin: one vector read back lane by lane, then an underflow on lane 0
    add(0, 1, 0, 2, V0, V1, 8'h00, 1, 0, 0);
    for (int k = 1; k <= ROW; k++) begin
      mask = 32'((64'd1 << (4 * k)) - 64'd1);
      add(0, 0, 1, 2, 0, (V1 & ~mask) | (V0 & mask), 8'(1 << (k - 1)), 0, k == ROW, 0);
    end
    add(0, 0, 1, 2, 0, V0, 8'h00, 0, 1, 1);
    // Skew: two-cycle read burst forms a wavefront across the lanes
    add(1, 0, 0, 0, 0,  0, 8'h00, 0, 1, 0);
    add(0, 1, 0, 1, V0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 1, V1, 0, 8'h00, 2, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 0, k < 2, 1, 0, sk_out[k], sk_val[k], (k == 0) ? 1 : 0, k >= 8, 0);

    for (int k = 0; k < vt.size(); k++) begin
      cycle(vt[k].rst, vt[k].wr, vt[k].rd, vt[k].mode, vt[k].din);
      chk($sformatf("tbl%0d_out", k),   bus.out,     vt[k].e_out);
      chk($sformatf("tbl%0d_valid", k), bus.o_valid, vt[k].e_valid);
      chk($sformatf("tbl%0d_count", k), bus.o_count, vt[k].e_count);
      chk($sformatf("tbl%0d_empty", k), bus.o_empty, vt[k].e_empty);
      chk($sformatf("tbl%0d_udf", k),   bus.o_udf,   vt[k].e_udf);
      chk($sformatf("tbl%0d_full", k),  bus.o_full,  1'b0);
      chk($sformatf("tbl%0d_ovf", k),   bus.o_ovf,   1'b0);
    end

    // Fill to DEPTH with pointers pre-offset so the drain crosses the wrap
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, $urandom);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < DEPTH; k++) cycle(0, 1, 0, 0, $urandom);
    chk("fill_full", bus.o_full, 1'b1);
    chk("fill_ready", bus.o_ready, 1'b0);
    chk("fill_count", bus.o_count, DEPTH);
    cycle(0, 1, 0, 0, $urandom);
    chk("ovf_flag", bus.o_ovf, 1'b1);
    chk("ovf_count", bus.o_count, DEPTH);
    for (int k = 0; k < DEPTH; k++) cycle(0, 0, 1, 0, 0);
    chk("drain_empty", bus.o_empty, 1'b1);

    // Steady concurrent write+read holds occupancy
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, $urandom);
    for (int k = 0; k < 100; k++) cycle(0, 1, 1, 0, $urandom);
    chk("conc_count", bus.o_count, 5);
    chk("conc_ovf", bus.o_ovf, 1'b0);
    chk("conc_udf", bus.o_udf, 1'b0);

    // Reset in the middle of a skew burst
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, $urandom);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    chk("mrst_out", bus.out, 32'h0);
    chk("mrst_valid", bus.o_valid, 8'h00);
    chk("mrst_empty", bus.o_empty, 1'b1);
    chk("mrst_count", bus.o_count, 0);
    chk("mrst_ready", bus.o_ready, 1'b1);

    // Mode change mid skew burst cancels the delayed reads
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, $urandom);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    for (int k = 0; k < ROW; k++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("mchg_valid%0d", k), bus.o_valid, 8'h00);
    end
    chk("mchg_count", bus.o_count, 2);
    chk("mchg_empty", bus.o_empty, 1'b0);

    // Randomized traffic
    cycle(1, 0, 0, 0, 0);
    begin
      logic [1:0] md;
      md = 2'd0;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
        cycle($urandom_range(0, 399) == 0, $urandom_range(0, 99) < 55,
              $urandom_range(0, 99) < 50, md, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
